// File: rtl/alu_div_seq.sv
// rtl/alu_div_seq.sv - iterative radix-2 restoring divider, signed/unsigned, RISC-V corner semantics.
// Optional DIV_EARLY_OUT_EN: corner cases bypass CALC and finish in 2 cycles.
module alu_div_seq #(
  parameter int N     = 64,
  parameter int CNT_W = 7
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         start_i,
  input  logic         signed_i,
  input  logic [N-1:0] dividend_i,
  input  logic [N-1:0] divisor_i,
  output logic         ready_o,
  output logic         busy_o,
  output logic         valid_o,
  output logic [N-1:0] quotient_o,
  output logic [N-1:0] remainder_o,
  output logic         dbz_o
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     rem_q, rem_d;
  logic [N-1:0]     dvd_q, dvd_d;
  logic [N-1:0]     dsr_q, dsr_d;
  logic [N-1:0]     raw_q, raw_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             dbzf_q, dbzf_d;
  logic             ovff_q, ovff_d;
`ifdef DIV_EARLY_OUT_EN
  logic             smallf_q, smallf_d;
  logic             is_small;
`endif
  logic [N-1:0]     quot_q, quot_d;
  logic [N-1:0]     remo_q, remo_d;
  logic             dbz_q, dbz_d;

  logic             sa, sb;
  logic [N-1:0]     a_abs, b_abs;
  logic             is_dbz, is_ovf;
  logic [N:0]       rem_sh;
  logic             rem_ge;
  logic [N-1:0]     rem_sub;
  logic [N-1:0]     q_fix, r_fix;

  assign sa     = signed_i & dividend_i[N-1];
  assign sb     = signed_i & divisor_i[N-1];
  assign a_abs  = sa ? -dividend_i : dividend_i;
  assign b_abs  = sb ? -divisor_i : divisor_i;
  assign is_dbz = (divisor_i == '0);
  assign is_ovf = signed_i && (dividend_i == {1'b1, {(N-1){1'b0}}}) && (divisor_i == {N{1'b1}});
`ifdef DIV_EARLY_OUT_EN
  assign is_small = (a_abs < b_abs);
`endif

  // Partial remainder stays below the divisor, so the N-bit modular difference is exact when taken.
  assign rem_sh  = {rem_q, dvd_q[N-1]};
  assign rem_ge  = (rem_sh >= {1'b0, dsr_q});
  assign rem_sub = rem_sh[N-1:0] - dsr_q;

  assign q_fix = negq_q ? -dvd_q : dvd_q;
  assign r_fix = negr_q ? -rem_q : rem_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dsr_d    = dsr_q;
    raw_d    = raw_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    dbzf_d   = dbzf_q;
    ovff_d   = ovff_q;
`ifdef DIV_EARLY_OUT_EN
    smallf_d = smallf_q;
`endif
    quot_d   = quot_q;
    remo_d   = remo_q;
    dbz_d    = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_CALC;
          cnt_d   = '0;
          rem_d   = '0;
          dvd_d   = a_abs;
          dsr_d   = b_abs;
          raw_d   = dividend_i;
          negq_d  = sa ^ sb;
          negr_d  = sa;
          dbzf_d  = is_dbz;
          ovff_d  = is_ovf;
`ifdef DIV_EARLY_OUT_EN
          smallf_d = is_small;
          if (is_dbz || is_ovf || is_small) begin
            state_d = S_FIX;
          end
`endif
        end
      end
      S_CALC: begin
        rem_d = rem_ge ? rem_sub : rem_sh[N-1:0];
        dvd_d = {dvd_q[N-2:0], rem_ge};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(N-1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_DONE;
        dbz_d   = dbzf_q;
        if (dbzf_q) begin
          quot_d = {N{1'b1}};
          remo_d = raw_q;
        end else if (ovff_q) begin
          quot_d = {1'b1, {(N-1){1'b0}}};
          remo_d = '0;
`ifdef DIV_EARLY_OUT_EN
        end else if (smallf_q) begin
          quot_d = '0;
          remo_d = raw_q;
`endif
        end else begin
          quot_d = q_fix;
          remo_d = r_fix;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      raw_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      dbzf_q   <= 1'b0;
      ovff_q   <= 1'b0;
`ifdef DIV_EARLY_OUT_EN
      smallf_q <= 1'b0;
`endif
      quot_q   <= '0;
      remo_q   <= '0;
      dbz_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dsr_q    <= dsr_d;
      raw_q    <= raw_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      dbzf_q   <= dbzf_d;
      ovff_q   <= ovff_d;
`ifdef DIV_EARLY_OUT_EN
      smallf_q <= smallf_d;
`endif
      quot_q   <= quot_d;
      remo_q   <= remo_d;
      dbz_q    <= dbz_d;
    end
  end

  assign ready_o     = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign valid_o     = (state_q == S_DONE);
  assign quotient_o  = quot_q;
  assign remainder_o = remo_q;
  assign dbz_o       = dbz_q;

endmodule

// File: tb/tb_alu_div_seq.sv
// tb/tb_alu_div_seq.sv - scoreboard bench for alu_div_seq with directed hand-computed vectors.
module tb_alu_div_seq;
  localparam int N = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         sgn;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         ready_o, busy_o, valid_o, dbz_o;
  logic [N-1:0] quotient_o, remainder_o;

  alu_div_seq #(.N(N), .CNT_W(7)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .start_i     (start),
    .signed_i    (sgn),
    .dividend_i  (dividend),
    .divisor_i   (divisor),
    .ready_o     (ready_o),
    .busy_o      (busy_o),
    .valid_o     (valid_o),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o),
    .dbz_o       (dbz_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           id;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dbz;
    int           lat;
    int           acc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

`ifdef DIV_EARLY_OUT_EN
  localparam int CORNER_LAT = 2;
`else
  localparam int CORNER_LAT = N + 2;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && valid_o !== 1'b0) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got valid_o=%b at cycle %0d expected no valid", valid_o, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check($sformatf("op%0d_quotient", mon_e.id), quotient_o, mon_e.q);
        check($sformatf("op%0d_remainder", mon_e.id), remainder_o, mon_e.r);
        check($sformatf("op%0d_dbz", mon_e.id), {{(N-1){1'b0}}, dbz_o}, {{(N-1){1'b0}}, mon_e.dbz});
        check($sformatf("op%0d_latency", mon_e.id), N'(cyc - mon_e.acc + 1), N'(mon_e.lat));
      end
    end
  end

  task automatic issue(input int id, input logic sg, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] q, input logic [N-1:0] r, input logic dbz, input logic corner);
    exp_t e;
    int   w;
    w = 0;
    @(negedge clk);
    while (ready_o !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (ready_o !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL op%0d_ready_timeout: got ready_o=%b expected 1 within 200 cycles", id, ready_o);
      return;
    end
    start    = 1'b1;
    sgn      = sg;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    e.id  = id;
    e.q   = q;
    e.r   = r;
    e.dbz = dbz;
    e.lat = corner ? CORNER_LAT : N + 2;
    e.acc = cyc;
    sb_q.push_back(e);
    start    = 1'b0;
    dividend = 64'hA5A5_A5A5_A5A5_A5A5;
    divisor  = 64'h5A5A_5A5A_5A5A_5A5A;
  endtask

  initial begin
    int w;
    rst_n    = 1'b0;
    start    = 1'b0;
    sgn      = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready", {63'd0, ready_o}, 64'd1);
    check("reset_busy", {63'd0, busy_o}, 64'd0);
    check("reset_valid", {63'd0, valid_o}, 64'd0);
    check("reset_quotient", quotient_o, 64'd0);
    check("reset_remainder", remainder_o, 64'd0);
    check("reset_dbz", {63'd0, dbz_o}, 64'd0);
    rst_n = 1'b1;

    issue(1, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 1'b0);
    issue(2, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    issue(3, 1'b1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 1'b0, 1'b0);
    issue(4, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    issue(5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    issue(6, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1'b1, 1'b1);
    issue(7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1, 1'b1);
    issue(8, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd0, 1'b0, 1'b1);
    issue(9, 1'b0, 64'd3, 64'd10, 64'd0, 64'd3, 1'b0, 1'b1);
    issue(10, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd10, 64'd0, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b1);
    issue(11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b0);
    issue(12, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 64'd1, 1'b0, 1'b0);
    issue(13, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    issue(14, 1'b1, 64'h8000_0000_0000_0000, 64'd1, 64'h8000_0000_0000_0000, 64'd0, 1'b0, 1'b0);
    issue(15, 1'b0, 64'hDEAD_BEEF_CAFE_BABE, 64'h10, 64'h0DEA_DBEE_FCAF_EBAB, 64'hE, 1'b0, 1'b0);
    issue(16, 1'b1, 64'd5, 64'd5, 64'd1, 64'd0, 1'b0, 1'b0);

    // Requests during a busy operation must be dropped.
    issue(17, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    check("busy_at_pulse1", {63'd0, busy_o}, 64'd1);
    start = 1'b1; sgn = 1'b0; dividend = 64'd5; divisor = 64'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    check("busy_at_pulse2", {63'd0, busy_o}, 64'd1);
    start = 1'b1; dividend = 64'd9; divisor = 64'd3;
    @(negedge clk);
    start = 1'b0;

    // Abort mid-CALC with a one-cycle reset.
    w = 0;
    while (ready_o !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    start = 1'b1; sgn = 1'b0; dividend = 64'd100; divisor = 64'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_ready", {63'd0, ready_o}, 64'd1);
    check("abort_valid", {63'd0, valid_o}, 64'd0);
    check("abort_quotient", quotient_o, 64'd0);
    check("abort_remainder", remainder_o, 64'd0);
    repeat (80) @(negedge clk);
    issue(18, 1'b0, 64'd200, 64'd9, 64'd22, 64'd2, 1'b0, 1'b0);

    w = 0;
    while (sb_q.size() != 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d outstanding results expected 0", sb_q.size());
    end
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
